alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Issue/writeback stage that sits directly upstream of the 32-bit ALU and also consumes its results. It accepts one instruction word per valid/ready handshake and decodes it. It then reads operands from an internal 32x32 register file and drives the ALU's alu_enable, alu_op, src1 and src2 inputs. It captures alu_out and alu_overflow and writes the result back, processing instructions serially: one instruction in flight at a time.

Parameters:
DATA_W, 32, datapath and register width
OP_W, 5, ALU opcode width
REG_N, 32, register count (index width 5)
MAX_OP, 5'b10001, highest legal opcode (SRLU)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction word present
instr_ready  out  1  block can accept an instruction
instr  in  32  [31:27] op, [26:22] rd, [21:17] rs1, [16:12] rs2, [11] imm_sel, [10:0] imm
alu_enable  out  1  to ALU
alu_op  out  5  to ALU
src1  out  32  to ALU
src2  out  32  to ALU
alu_out  in  32  from ALU (combinational)
alu_overflow  in  1  from ALU
done  out  1  one-cycle pulse when an instruction retires
ovf_sticky  out  1  set by any retired overflow
ovf_clr  in  1  synchronous clear of ovf_sticky
illegal_sticky  out  1  set by any opcode > MAX_OP
dbg_addr  in  5  debug read index
dbg_data  out  32  combinational read of reg[dbg_addr]; r0 reads 0

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-low.
- While rst=0: state=IDLE, all registers=0, alu_enable=0, alu_op=0, src1=0, src2=0, done=0, ovf_sticky=0, illegal_sticky=0, instr_ready=0.
- instr_ready rises in the first cycle after rst deasserts.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On valid&ready at edge T, latch op/rd/rs1/rs2/imm_sel/imm and go to EXEC.
  - Operands are read at that same edge: src1=reg[rs1]; src2 = imm_sel ? {21'b0,imm} : reg[rs2].
- EXEC (cycle T+1):
  - instr_ready=0; alu_enable=1 if op<=MAX_OP, else 0; alu_op, src1 and src2 stay stable all cycle.
  - At the edge, capture alu_out into result_q and alu_overflow into ovf_q.
  - Then go to WB.
- WB (cycle T+2):
  - done=1; alu_enable=0; instr_ready=0.
  - At the edge, write result_q to reg[rd] only if op is legal and rd!=0.
  - At the same edge, ovf_sticky is set if the op is legal and ovf_q=1.
  - Then go to IDLE.
- Throughput is one instruction per 3 cycles; the new value is visible on dbg_data from cycle T+3.
- Outside EXEC, src1/src2/alu_op hold their last values; only alu_enable is gated.
- r0 always reads 0, and writes to r0 are discarded with no side effects.
- Illegal op (op > MAX_OP): the instruction still traverses EXEC/WB and done pulses. There is no write and no overflow update; illegal_sticky is set at the WB edge.
- ovf_clr=1 clears ovf_sticky on the next edge. If the set and the clear hit the same edge, the set wins.
- instr_valid while not ready: the instruction is not consumed, and the bench must hold it until ready.
- Reset mid-operation (any state): immediate return to IDLE with no writeback; the in-flight instruction is lost.
- Operand hazards are impossible because of serial issue. An instruction with rs1==rd of the previous instruction reads the updated value.

Test Plan:
- Immediate load: reset, then ADD rd=1, rs1=0, imm_sel=1, imm=0x7FF. Expect instr_ready=0 for T+1..T+2, alu_enable=1 only at T+1 with src1=0 and src2=0x7FF, done at T+2, and dbg_data(1)=0x000007FF at T+3.
- Shift then overflow:
  - SLL r2=r1, imm=20 gives r2=0x7FF00000.
  - ADD r3=r2+r2 (imm_sel=0) gives r3=0xFFE00000 and ovf_sticky=1.
  - ovf_clr pulse then gives ovf_sticky=0.
- Write to r0: ADD rd=0, rs1=1, imm=5. Expect done to pulse and dbg_data(0)=0.
- Illegal op 5'b11111 with rd=4: alu_enable stays 0, done pulses, r4 unchanged (0), illegal_sticky=1.
- Backpressure: instr_valid held high across three back-to-back instructions. Expect exactly three accepts, 3 cycles apart, and three done pulses.
- Reset in EXEC:
  - Assert rst=0 mid-cycle during ADD rd=5. Outputs go 0 immediately (asynchronous).
  - After release, r5=0, no done pulse, and instr_ready=1 one cycle later.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Serial issue/writeback controller in front of a 32-bit ALU: decodes one instruction,
// drives the ALU for one cycle, then writes the captured result to a 32x32 register file.
module alu_issue_ctrl #(
   parameter int unsigned      DATA_W = 32,
   parameter int unsigned      OP_W   = 5,
   parameter int unsigned      REG_N  = 32,
   parameter logic [OP_W-1:0]  MAX_OP = 5'b10001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic              alu_enable,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_overflow,
   output logic              done,
   output logic              ovf_sticky,
   input  logic              ovf_clr,
   output logic              illegal_sticky,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int unsigned AW = $clog2(REG_N);

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e              state_q, state_d;
   logic                run_q;
   logic [OP_W-1:0]     op_q;
   logic [AW-1:0]       rd_q;
   logic [DATA_W-1:0]   src1_q, src2_q, result_q;
   logic                ovf_q;
   logic                ovf_sticky_q, ovf_sticky_d;
   logic                illegal_sticky_q, illegal_sticky_d;
   logic [DATA_W-1:0]   rf_q [REG_N];

   logic                accept, rf_we, legal;
   logic [AW-1:0]       rs1_idx, rs2_idx;
   logic [DATA_W-1:0]   rs1_val, rs2_val, imm_ext;

   assign rs1_idx = instr[21:17];
   assign rs2_idx = instr[16:12];
   assign imm_ext = {{(DATA_W-11){1'b0}}, instr[10:0]};

   // r0 is hardwired to zero on every read port
   assign rs1_val  = (rs1_idx == '0)  ? '0 : rf_q[rs1_idx];
   assign rs2_val  = (rs2_idx == '0)  ? '0 : rf_q[rs2_idx];
   assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

   assign legal          = (op_q <= MAX_OP);
   assign alu_op         = op_q;
   assign src1           = src1_q;
   assign src2           = src2_q;
   assign ovf_sticky     = ovf_sticky_q;
   assign illegal_sticky = illegal_sticky_q;

   always_comb begin
      state_d          = state_q;
      instr_ready      = 1'b0;
      alu_enable       = 1'b0;
      done             = 1'b0;
      accept           = 1'b0;
      rf_we            = 1'b0;
      ovf_sticky_d     = ovf_clr ? 1'b0 : ovf_sticky_q;
      illegal_sticky_d = illegal_sticky_q;
      case (state_q)
         StIdle: begin
            instr_ready = run_q;
            if (instr_valid && run_q) begin
               accept  = 1'b1;
               state_d = StExec;
            end
         end
         StExec: begin
            alu_enable = legal;
            state_d    = StWb;
         end
         StWb: begin
            done  = 1'b1;
            rf_we = legal && (rd_q != '0);
            // a set on the same edge as a clear takes priority
            if (legal && ovf_q) ovf_sticky_d = 1'b1;
            if (!legal) illegal_sticky_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= StIdle;
         run_q            <= 1'b0;
         op_q             <= '0;
         rd_q             <= '0;
         src1_q           <= '0;
         src2_q           <= '0;
         result_q         <= '0;
         ovf_q            <= 1'b0;
         ovf_sticky_q     <= 1'b0;
         illegal_sticky_q <= 1'b0;
         for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
      end else begin
         state_q          <= state_d;
         run_q            <= 1'b1;
         ovf_sticky_q     <= ovf_sticky_d;
         illegal_sticky_q <= illegal_sticky_d;
         if (accept) begin
            op_q   <= instr[31:27];
            rd_q   <= instr[26:22];
            src1_q <= rs1_val;
            src2_q <= instr[11] ? imm_ext : rs2_val;
         end
         if (state_q == StExec) begin
            result_q <= alu_out;
            ovf_q    <= alu_overflow;
         end
         if (rf_we) rf_q[rd_q] <= result_q;
      end
   end

endmodule
